decoder_multiblock: RTL and testbench

//  Parametrised 64b/66b receive decoder: N_BLOCKS 66b blocks per clock.

---
 rtl/decoder_pkg.sv | 30 +++
 rtl/decoder_block_classifier.sv | 61 ++++++
 rtl/decoder_multiblock.sv | 93 +++++++++
 tb/tb_decoder_multiblock.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: 64b/66b block codes, XGMII characters, block types and receive FSM rules
package decoder_pkg;
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;
  localparam logic [7:0] BT_C = 8'h1E;
  localparam logic [7:0] BT_O = 8'h4B;
  localparam logic [7:0] BT_S = 8'h78;
  localparam logic [7:0] BT_T [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
  localparam logic [6:0] CC_I = 7'h00;
  localparam logic [6:0] CC_E = 7'h1E;
  localparam logic [7:0] CH_I = 8'h07;
  localparam logic [7:0] CH_E = 8'hFE;
  localparam logic [7:0] CH_S = 8'hFB;
  localparam logic [7:0] CH_T = 8'hFD;
  localparam logic [7:0] CH_O = 8'h9C;
  typedef enum logic [2:0] {RX_INIT = 3'd0, RX_C = 3'd1, RX_D = 3'd2, RX_T = 3'd3, RX_E = 3'd4} rx_state_e;
  typedef enum logic [2:0] {BLK_D, BLK_C, BLK_S, BLK_T, BLK_E} blk_type_e;
  function automatic logic [3:0] term_k(input logic [7:0] bt);
    term_k = 4'd0;
    for (int k = 0; k < 8; k++)
      if (bt == BT_T[k]) term_k = {1'b1, 3'(k)};
  endfunction
  function automatic rx_state_e rx_next(input rx_state_e s, input blk_type_e t, input blk_type_e tn);
    logic t_ok;
    t_ok = t == BLK_T && (tn == BLK_C || tn == BLK_S);
    if (s == RX_D) rx_next = t == BLK_D ? RX_D : t_ok ? RX_T : RX_E;
    else if (s == RX_E) rx_next = t == BLK_C ? RX_C : t == BLK_D ? RX_D : t_ok ? RX_T : RX_E;
    else rx_next = t == BLK_C ? RX_C : t == BLK_S ? RX_D : RX_E;
  endfunction
endpackage

// File: rtl/decoder_block_classifier.sv
// decoder_block_classifier: classifies one 66b block and decodes its lanes/ctrl flags
module decoder_block_classifier
  import decoder_pkg::*;
(
  input  logic [65:0] blk,
  output blk_type_e   typ,
  output logic [63:0] data,
  output logic [7:0]  ctrl
);
  logic [63:0] p;
  logic [7:0] bt;
  logic [3:0] tk;
  logic c_ok;
  logic [63:0] c_data;
  logic [63:0] t_src;
  logic [63:0] t_data;
  assign p = blk[63:0];
  assign bt = p[63:56];
  assign tk = term_k(bt);
  assign t_src = {p[55:0], CH_I};
  always_comb begin
    c_ok = 1'b1;
    c_data = '0;
    for (int i = 0; i < 8; i++) begin
      c_data[63-8*i -: 8] = p[55-7*i -: 7] == CC_E ? CH_E : CH_I;
      if (p[55-7*i -: 7] != CC_I && p[55-7*i -: 7] != CC_E) c_ok = 1'b0;
    end
  end
  always_comb begin
    t_data = {8{CH_I}};
    for (int i = 0; i < 8; i++)
      t_data[63-8*i -: 8] = i < int'(tk[2:0]) ? t_src[63-8*i -: 8] : i == int'(tk[2:0]) ? CH_T : CH_I;
  end
  always_comb begin
    typ = BLK_E;
    data = {8{CH_E}};
    ctrl = 8'hFF;
    if (blk[65:64] == SYNC_DATA) begin
      typ = BLK_D;
      data = p;
      ctrl = 8'h00;
    end else if (blk[65:64] == SYNC_CTRL) begin
      if (bt == BT_C && c_ok) begin
        typ = BLK_C;
        data = c_data;
      end else if (bt == BT_O) begin
        typ = BLK_C;
        data = {CH_O, p[55:32], {4{CH_I}}};
        ctrl = 8'h8F;
      end else if (bt == BT_S) begin
        typ = BLK_S;
        data = {CH_S, p[55:0]};
        ctrl = 8'h80;
      end else if (tk[3]) begin
        typ = BLK_T;
        data = t_data;
        ctrl = 8'hFF >> tk[2:0];
      end
    end
  end
endmodule

// File: rtl/decoder_multiblock.sv
// decoder_multiblock: N-block 64b/66b receive decoder with chained FSM, one-word lookahead and error counter
module decoder_multiblock
  import decoder_pkg::*;
#(
  parameter int N_BLOCKS      = 2,
  parameter int NB_DATA_CODED = 66,
  parameter int NB_DATA_RAW   = 64,
  parameter int NB_CTRL       = 8,
  parameter int NB_ERR_CNT    = 16
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_enable,
  input  logic                              i_valid,
  input  logic [N_BLOCKS*NB_DATA_CODED-1:0] i_data,
  input  logic                              i_clear_err,
  output logic                              o_valid,
  output logic [N_BLOCKS*NB_DATA_RAW-1:0]   o_data,
  output logic [N_BLOCKS*NB_CTRL-1:0]       o_ctrl,
  output logic [2:0]                        o_fsm_state,
  output logic [N_BLOCKS-1:0]               o_err_blocks,
  output logic [NB_ERR_CNT-1:0]             o_err_count
);
  logic [N_BLOCKS*NB_DATA_CODED-1:0] held;
  logic held_valid;
  rx_state_e state;
  rx_state_e s_chain;
  logic [(N_BLOCKS+1)*NB_DATA_CODED-1:0] blocks;
  blk_type_e typ [N_BLOCKS+1];
  logic [NB_DATA_RAW-1:0] dec_data [N_BLOCKS+1];
  logic [NB_CTRL-1:0] dec_ctrl [N_BLOCKS+1];
  logic [N_BLOCKS*NB_DATA_RAW-1:0] nx_data;
  logic [N_BLOCKS*NB_CTRL-1:0] nx_ctrl;
  logic [N_BLOCKS-1:0] nx_err;
  logic accept;
  logic fire;
  logic [NB_ERR_CNT-1:0] cnt_base;
  logic [NB_ERR_CNT:0] cnt_sum;
  logic [NB_ERR_CNT-1:0] cnt_next;
  assign accept = i_enable & i_valid;
  assign fire = accept & held_valid;
  assign blocks = {i_data[NB_DATA_CODED-1:0], held};
  assign o_fsm_state = state;
  genvar b;
  for (b = 0; b <= N_BLOCKS; b++) begin : g_cls
    decoder_block_classifier u_cls (
      .blk  (blocks[b*NB_DATA_CODED +: NB_DATA_CODED]),
      .typ  (typ[b]),
      .data (dec_data[b]),
      .ctrl (dec_ctrl[b])
    );
  end
  always_comb begin
    s_chain = state;
    nx_data = '0;
    nx_ctrl = '0;
    nx_err = '0;
    for (int i = 0; i < N_BLOCKS; i++) begin
      s_chain = rx_next(s_chain, typ[i], typ[i+1]);
      nx_err[i] = s_chain == RX_E;
      nx_data[i*NB_DATA_RAW +: NB_DATA_RAW] = nx_err[i] ? {8{CH_E}} : dec_data[i];
      nx_ctrl[i*NB_CTRL +: NB_CTRL] = nx_err[i] ? 8'hFF : dec_ctrl[i];
    end
  end
  assign cnt_base = i_clear_err ? '0 : o_err_count;
  assign cnt_sum = {1'b0, cnt_base} + (NB_ERR_CNT+1)'(fire ? $countones(nx_err) : 0);
  assign cnt_next = cnt_sum[NB_ERR_CNT] ? '1 : cnt_sum[NB_ERR_CNT-1:0];
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      held <= '0;
      held_valid <= 1'b0;
      state <= RX_INIT;
      o_valid <= 1'b0;
      o_data <= '0;
      o_ctrl <= '0;
      o_err_blocks <= '0;
      o_err_count <= '0;
    end else if (i_enable) begin
      o_valid <= fire;
      o_err_count <= cnt_next;
      if (accept) begin
        held <= i_data;
        held_valid <= 1'b1;
      end
      if (fire) begin
        state <= s_chain;
        o_data <= nx_data;
        o_ctrl <= nx_ctrl;
        o_err_blocks <= nx_err;
      end
    end
  end
endmodule

// File: tb/tb_decoder_multiblock.sv
// tb_decoder_multiblock: directed plus random stimulus against a behavioural 64b/66b receive model
module tb_decoder_multiblock;
  localparam int N = 2;
  localparam int CW = 4;
  localparam int W = N*66;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic vld = 1'b0;
  logic clr = 1'b0;
  logic [W-1:0] din = '0;
  logic o_valid;
  logic [N*64-1:0] o_data;
  logic [N*8-1:0] o_ctrl;
  logic [2:0] o_fsm_state;
  logic [N-1:0] o_err_blocks;
  logic [CW-1:0] o_err_count;
  int total = 0;
  int bad = 0;
  logic in_pkt = 1'b0;
  logic [W-1:0] m_held;
  logic m_hv;
  logic [2:0] m_state;
  logic [CW-1:0] m_cnt;
  logic m_oval;
  logic [N*64-1:0] m_data;
  logic [N*8-1:0] m_ctrl;
  logic [N-1:0] m_err;
  decoder_multiblock #(.N_BLOCKS(N), .NB_ERR_CNT(CW)) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_enable     (en),
    .i_valid      (vld),
    .i_data       (din),
    .i_clear_err  (clr),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_ctrl       (o_ctrl),
    .o_fsm_state  (o_fsm_state),
    .o_err_blocks (o_err_blocks),
    .o_err_count  (o_err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] t_type(input int k);
    case (k)
      0: return 8'h87;
      1: return 8'h99;
      2: return 8'hAA;
      3: return 8'hB4;
      4: return 8'hCC;
      5: return 8'hD2;
      6: return 8'hE1;
      default: return 8'hFF;
    endcase
  endfunction
  function automatic logic [65:0] blk_c(input logic [55:0] codes);
    return {2'b10, 8'h1E, codes};
  endfunction
  function automatic logic [65:0] blk_s(input logic [55:0] p);
    return {2'b10, 8'h78, p};
  endfunction
  function automatic logic [65:0] blk_d(input logic [63:0] p);
    return {2'b01, p};
  endfunction
  function automatic logic [65:0] blk_t(input int k, input logic [55:0] p);
    return {2'b10, t_type(k), p};
  endfunction
  // type codes: 0 D, 1 C, 2 S, 3 T, 4 E
  function automatic void mdec(input logic [65:0] b, output int t, output logic [63:0] d, output logic [7:0] c);
    logic [7:0] by [8];
    logic [6:0] code;
    int k;
    for (int j = 0; j < 8; j++) by[j] = b[63-8*j -: 8];
    t = 4;
    d = {8{8'hFE}};
    c = 8'hFF;
    k = -1;
    for (int j = 0; j < 8; j++) if (by[0] == t_type(j)) k = j;
    if (b[65:64] == 2'b01) begin
      t = 0;
      d = b[63:0];
      c = 8'h00;
    end else if (b[65:64] == 2'b10) begin
      if (by[0] == 8'h1E) begin
        t = 1;
        for (int j = 0; j < 8; j++) begin
          code = 7'(b[55:0] >> (7*(7-j)));
          if (code == 7'h00) d[63-8*j -: 8] = 8'h07;
          else if (code == 7'h1E) d[63-8*j -: 8] = 8'hFE;
          else t = 4;
        end
        if (t == 4) d = {8{8'hFE}};
      end else if (by[0] == 8'h4B) begin
        t = 1;
        d = {8'h9C, by[1], by[2], by[3], 32'h07070707};
        c = 8'h8F;
      end else if (by[0] == 8'h78) begin
        t = 2;
        d = {8'hFB, b[55:0]};
        c = 8'h80;
      end else if (k >= 0) begin
        t = 3;
        for (int j = 0; j < 8; j++) begin
          d[63-8*j -: 8] = j < k ? by[(j+1)%8] : j == k ? 8'hFD : 8'h07;
          c[7-j] = j >= k;
        end
      end
    end
  endfunction
  function automatic logic [2:0] mnext(input logic [2:0] s, input int t, input int tn);
    logic term_ok;
    term_ok = t == 3 && (tn == 1 || tn == 2);
    case (s)
      3'd2: return t == 0 ? 3'd2 : term_ok ? 3'd3 : 3'd4;
      3'd4: return t == 1 ? 3'd1 : t == 0 ? 3'd2 : term_ok ? 3'd3 : 3'd4;
      default: return t == 1 ? 3'd1 : t == 2 ? 3'd2 : 3'd4;
    endcase
  endfunction
  task automatic mreset();
    m_held = '0;
    m_hv = 1'b0;
    m_state = 3'd0;
    m_cnt = '0;
    m_oval = 1'b0;
    m_data = '0;
    m_ctrl = '0;
    m_err = '0;
  endtask
  task automatic step(input logic v, input logic [W-1:0] d, input logic c = 1'b0, input logic e = 1'b1);
    int ts [N+1];
    logic [63:0] dd [N+1];
    logic [7:0] cc [N+1];
    logic [2:0] s;
    int ne;
    int sum;
    logic [W-1:0] n_held;
    logic n_hv;
    logic [2:0] n_state;
    logic [CW-1:0] n_cnt;
    logic n_oval;
    logic [N*64-1:0] n_data;
    logic [N*8-1:0] n_ctrl;
    logic [N-1:0] n_err;
    vld = v;
    din = d;
    clr = c;
    en = e;
    n_held = m_held;
    n_hv = m_hv;
    n_state = m_state;
    n_cnt = m_cnt;
    n_oval = m_oval;
    n_data = m_data;
    n_ctrl = m_ctrl;
    n_err = m_err;
    if (e) begin
      n_oval = v && m_hv;
      ne = 0;
      if (n_oval) begin
        for (int b = 0; b < N; b++) mdec(m_held[b*66 +: 66], ts[b], dd[b], cc[b]);
        mdec(d[65:0], ts[N], dd[N], cc[N]);
        s = m_state;
        for (int b = 0; b < N; b++) begin
          s = mnext(s, ts[b], ts[b+1]);
          n_err[b] = s == 3'd4;
          n_data[b*64 +: 64] = s == 3'd4 ? {8{8'hFE}} : dd[b];
          n_ctrl[b*8 +: 8] = s == 3'd4 ? 8'hFF : cc[b];
          if (s == 3'd4) ne++;
        end
        n_state = s;
      end
      sum = (c ? 0 : int'(m_cnt)) + ne;
      n_cnt = sum > (1 << CW) - 1 ? CW'((1 << CW) - 1) : CW'(sum);
      if (v) begin
        n_held = d;
        n_hv = 1'b1;
      end
    end
    @(posedge clk);
    m_held = n_held;
    m_hv = n_hv;
    m_state = n_state;
    m_cnt = n_cnt;
    m_oval = n_oval;
    m_data = n_data;
    m_ctrl = n_ctrl;
    m_err = n_err;
    #2;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    vld = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    in_pkt = 1'b0;
    mreset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask
  task automatic gen_word(output logic [W-1:0] w);
    for (int b = 0; b < N; b++) begin
      int r;
      logic [65:0] x;
      r = $urandom_range(0, 99);
      if (r < 4) x = {2'($urandom_range(0, 3)), $urandom, $urandom};
      else if (r < 7) x = {2'b10, 8'($urandom), $urandom, 24'($urandom)};
      else if (!in_pkt) begin
        if (r < 60) x = blk_c('0);
        else if (r < 68) x = blk_c(56'h1E << (7*$urandom_range(0, 7)));
        else if (r < 73) x = {2'b10, 8'h4B, 56'({$urandom, $urandom})};
        else begin
          x = blk_s(56'({$urandom, $urandom}));
          in_pkt = 1'b1;
        end
      end else begin
        if (r < 75) x = blk_d({$urandom, $urandom});
        else begin
          x = blk_t($urandom_range(0, 7), 56'({$urandom, $urandom}));
          in_pkt = 1'b0;
        end
      end
      w[b*66 +: 66] = x;
    end
  endtask
  always @(negedge clk) begin
    chk("o_valid", 128'(o_valid), 128'(m_oval));
    chk("o_data", o_data, m_data);
    chk("o_ctrl", 128'(o_ctrl), 128'(m_ctrl));
    chk("o_err_blocks", 128'(o_err_blocks), 128'(m_err));
    chk("o_fsm_state", 128'(o_fsm_state), 128'(m_state));
    chk("o_err_count", 128'(o_err_count), 128'(m_cnt));
  end
  initial begin
    logic [W-1:0] idle;
    logic [W-1:0] w;
    logic [65:0] bs;
    mreset();
    idle = {blk_c('0), blk_c('0)};
    bs = {2'b00, 64'h0};
    do_reset();
    // idle stream
    step(1, idle);
    step(1, idle);
    chk("t1_valid", 128'(o_valid), 128'd1);
    chk("t1_data", o_data, {16{8'h07}});
    chk("t1_ctrl", 128'(o_ctrl), 128'hFFFF);
    chk("t1_state", 128'(o_fsm_state), 128'd1);
    chk("t1_count", 128'(o_err_count), 128'd0);
    // S,D then D,T3 then idle
    do_reset();
    step(1, idle);
    step(1, {blk_d(64'h0123456789ABCDEF), blk_s(56'h11223344556677)});
    step(1, {blk_t(3, 56'h112233445566AA), blk_d(64'hCAFEBABE00000001)});
    chk("t2_s_lane0", 128'(o_data[63:56]), 128'hFB);
    chk("t2_s_data", 128'(o_data[63:0]), 128'hFB11223344556677);
    chk("t2_s_ctrl", 128'(o_ctrl[7:0]), 128'h80);
    step(1, idle);
    chk("t2_t3_data", 128'(o_data[127:64]), 128'h112233FD07070707);
    chk("t2_t3_ctrl", 128'(o_ctrl[15:8]), 128'h1F);
    chk("t2_t3_state", 128'(o_fsm_state), 128'd3);
    chk("t2_t3_err", 128'(o_err_blocks), 128'd0);
    step(1, idle);
    chk("t2_end_state", 128'(o_fsm_state), 128'd1);
    chk("t2_count", 128'(o_err_count), 128'd0);
    // T5 followed by D is illegal
    do_reset();
    step(1, idle);
    step(1, {blk_d(64'h1), blk_s(56'h0)});
    step(1, {blk_t(5, 56'hA1A2A3A4A5A6A7), blk_d(64'h2)});
    step(1, {idle[131:66], blk_d(64'h3)});
    chk("t3_err", 128'(o_err_blocks), 128'b10);
    chk("t3_data", 128'(o_data[127:64]), {64'h0, {8{8'hFE}}});
    chk("t3_ctrl", 128'(o_ctrl[15:8]), 128'hFF);
    chk("t3_state", 128'(o_fsm_state), 128'd4);
    chk("t3_count", 128'(o_err_count), 128'd1);
    // bad sync header in an idle word
    do_reset();
    step(1, idle);
    step(1, {bs, blk_c('0)});
    step(1, idle);
    chk("t4_err", 128'(o_err_blocks), 128'b10);
    chk("t4_data", o_data, {{8{8'hFE}}, {8{8'h07}}});
    chk("t4_count", 128'(o_err_count), 128'd1);
    step(1, idle);
    chk("t4_recover", 128'(o_fsm_state), 128'd1);
    // valid gaps stall the held word
    do_reset();
    step(1, {blk_c('0), blk_c(56'h1E << 35)});
    step(0, {bs, bs});
    chk("t5_gap1", 128'(o_valid), 128'd0);
    step(0, {bs, bs});
    chk("t5_gap2", 128'(o_valid), 128'd0);
    step(1, idle);
    chk("t5_valid", 128'(o_valid), 128'd1);
    chk("t5_data", o_data, {{8{8'h07}}, 64'h0707FE0707070707});
    step(0, idle);
    chk("t5_pulse", 128'(o_valid), 128'd0);
    // saturation, clear and mid-packet reset
    do_reset();
    repeat (11) step(1, {bs, bs});
    chk("t6_sat", 128'(o_err_count), 128'd15);
    step(1, {bs, bs}, 1'b1);
    chk("t6_clear", 128'(o_err_count), 128'd2);
    step(1, {blk_d(64'h5), blk_s(56'h0)});
    step(1, {blk_d(64'h6), blk_d(64'h7)});
    rst_n = 1'b0;
    mreset();
    #1;
    chk("t6_rst_valid", 128'(o_valid), 128'd0);
    chk("t6_rst_data", o_data, 128'd0);
    chk("t6_rst_count", 128'(o_err_count), 128'd0);
    chk("t6_rst_state", 128'(o_fsm_state), 128'd0);
    do_reset();
    step(1, idle);
    chk("t6_no_partial", 128'(o_valid), 128'd0);
    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      gen_word(w);
      step($urandom_range(0, 9) < 8, w, $urandom_range(0, 29) == 0, $urandom_range(0, 19) != 0);
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
